// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC and sequences instruction fetch/execute for the multicycle core.
// Computes the next PC (seq/beq/j), counts retired instructions and raises a sticky fetch-timeout fault.
module pc_sequencer #(
   parameter logic [29:0] RESET_PC = 30'h0000_0C00,
   parameter logic [7:0]  TIMEOUT  = 8'd255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   output logic        imem_req,
   output logic [29:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir,
   output logic        ir_valid,
   input  logic        ex_done,
   input  logic [1:0]  npc_op,
   input  logic        zero,
   output logic [29:0] pc,
   output logic [31:0] retired,
   output logic        fault
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      FAULT = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [29:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic        ir_valid_q, ir_valid_d;
   logic        imem_req_q, imem_req_d;
   logic [31:0] retired_q, retired_d;
   logic        fault_q, fault_d;
   logic [7:0]  wdog_q, wdog_d;

   logic [29:0] br_off;
   logic [29:0] next_pc;

   // Branch offset is relative to the current pc, not pc+1.
   always_comb begin
      br_off = {{14{ir_q[15]}}, ir_q[15:0]};
      case (npc_op)
         2'b01:   next_pc = zero ? (pc_q + br_off) : (pc_q + 30'd1);
         2'b10:   next_pc = {pc_q[29:26], ir_q[25:0]};
         default: next_pc = pc_q + 30'd1;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_valid_d = 1'b0;
      imem_req_d = 1'b0;
      retired_d  = retired_q;
      fault_d    = fault_q;
      wdog_d     = wdog_q;

      case (state_q)
         IDLE: begin
            if (run) begin
               state_d    = FETCH;
               imem_req_d = 1'b1;
               wdog_d     = '0;
            end
         end
         FETCH: begin
            // An ack on the final watchdog cycle still wins over the timeout.
            if (imem_ack) begin
               ir_d       = imem_rdata;
               ir_valid_d = 1'b1;
               state_d    = EXEC;
               wdog_d     = '0;
            end else if (wdog_q == TIMEOUT) begin
               state_d = FAULT;
               fault_d = 1'b1;
            end else begin
               wdog_d     = wdog_q + 8'd1;
               imem_req_d = 1'b1;
            end
         end
         EXEC: begin
            if (ex_done) begin
               pc_d      = next_pc;
               retired_d = retired_q + 32'd1;
               if (run) begin
                  state_d    = FETCH;
                  imem_req_d = 1'b1;
                  wdog_d     = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            fault_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         imem_req_q <= 1'b0;
         retired_q  <= '0;
         fault_q    <= 1'b0;
         wdog_q     <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         imem_req_q <= imem_req_d;
         retired_q  <= retired_d;
         fault_q    <= fault_d;
         wdog_q     <= wdog_d;
      end
   end

   assign imem_req  = imem_req_q;
   assign imem_addr = pc_q;
   assign ir        = ir_q;
   assign ir_valid  = ir_valid_q;
   assign pc        = pc_q;
   assign retired   = retired_q;
   assign fault     = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus for pc_sequencer with a transaction-level reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_pc_sequencer;

   localparam logic [29:0] RST_PC = 30'h0000_0C00;
   localparam int          TMO    = 255;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        imem_req;
   logic [29:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] ir;
   logic        ir_valid;
   logic        ex_done = 1'b0;
   logic [1:0]  npc_op = 2'b00;
   logic        zero = 1'b0;
   logic [29:0] pc;
   logic [31:0] retired;
   logic        fault;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   pc_sequencer #(.RESET_PC(RST_PC), .TIMEOUT(8'd255)) dut (
      .clk(clk), .rst(rst), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .ir(ir), .ir_valid(ir_valid),
      .ex_done(ex_done), .npc_op(npc_op), .zero(zero),
      .pc(pc), .retired(retired), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase flags, a fetch-age counter and plain integer PC arithmetic.
   bit          m_fetching = 0, m_executing = 0, m_faulted = 0, m_ir_valid = 0;
   int          m_age = 0;
   logic [29:0] m_pc = RST_PC;
   logic [31:0] m_ir = '0;
   logic [31:0] m_retired = '0;

   function automatic logic [29:0] model_next(input logic [29:0] p, input logic [31:0] instr,
                                              input logic [1:0] op, input logic z);
      longint t;
      int     off;
      if (op == 2'b10) return {p[29:26], instr[25:0]};
      off = int'(instr[15:0]);
      if (instr[15]) off = off - 65536;
      t = longint'(p);
      if (op == 2'b01 && z) t = t + off;
      else t = t + 1;
      return t[29:0];
   endfunction

   always @(posedge clk) begin
      m_ir_valid = 1'b0;
      if (rst) begin
         m_fetching = 0; m_executing = 0; m_faulted = 0; m_age = 0;
         m_pc = RST_PC; m_ir = '0; m_retired = '0;
      end else if (m_faulted) begin
      end else if (m_fetching) begin
         if (imem_ack) begin
            m_ir = imem_rdata; m_ir_valid = 1'b1;
            m_fetching = 0; m_executing = 1;
         end else begin
            m_age++;
            if (m_age > TMO) begin m_fetching = 0; m_faulted = 1; end
         end
      end else if (m_executing) begin
         if (ex_done) begin
            m_pc = model_next(m_pc, m_ir, npc_op, zero);
            m_retired = m_retired + 32'd1;
            m_executing = 0;
            if (run) begin m_fetching = 1; m_age = 0; end
         end
      end else if (run) begin
         m_fetching = 1; m_age = 0;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("req",      imem_req,  m_fetching);
         check("addr",     imem_addr, m_pc);
         check("pc",       pc,        m_pc);
         check("ir",       ir,        m_ir);
         check("ir_valid", ir_valid,  m_ir_valid);
         check("retired",  retired,   m_retired);
         check("fault",    fault,     m_faulted);
      end
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1; run = 1'b0; imem_ack = 1'b0; ex_done = 1'b0;
      step(); step();
      rst = 1'b0;
   endtask

   // Waits for a request, acks immediately, then completes execute with the given next-pc control.
   task automatic do_instr(input logic [31:0] instr, input logic [1:0] op, input logic z,
                           input logic keep_run, output logic [29:0] addr);
      int n = 0;
      addr = '0;
      while (imem_req !== 1'b1 && n < 10) begin step(); n++; end
      if (imem_req !== 1'b1) begin
         check("req_timeout", 32'd0, 32'd1);
         return;
      end
      addr = imem_addr;
      imem_ack = 1'b1; imem_rdata = instr;
      step();
      imem_ack = 1'b0;
      ex_done = 1'b1; npc_op = op; zero = z; run = keep_run;
      step();
      ex_done = 1'b0; npc_op = 2'b00; zero = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "simulation time bound exceeded");
   end

   initial begin
      logic [29:0] a0, a1, a2, ad;
      int n;

      step();
      cmp_en = 1'b1;
      step();
      check("rst_pc", pc, RST_PC);
      check("rst_req", imem_req, 1'b0);
      check("rst_retired", retired, 32'd0);
      rst = 1'b0;

      // sequential fetch of three instructions
      run = 1'b1;
      do_instr(32'h0000_0001, 2'b00, 1'b0, 1'b1, a0);
      do_instr(32'h0000_0002, 2'b00, 1'b0, 1'b1, a1);
      do_instr(32'h0000_0003, 2'b00, 1'b0, 1'b1, a2);
      check("t1_addr0", a0, 30'h0000_0C00);
      check("t1_addr1", a1, 30'h0000_0C01);
      check("t1_addr2", a2, 30'h0000_0C02);
      check("t1_retired", retired, 32'd3);

      // beq taken/not-taken from pc 0xC05 with offset -2
      do_instr(32'h0, 2'b00, 1'b0, 1'b1, ad);
      do_instr(32'h0, 2'b00, 1'b0, 1'b1, ad);
      do_instr(32'h0000_FFFE, 2'b01, 1'b1, 1'b1, ad);
      check("t2_addr_beq", ad, 30'h0000_0C05);
      check("t2_taken", pc, 30'h0000_0C03);
      do_instr(32'h0, 2'b00, 1'b0, 1'b1, ad);
      do_instr(32'h0, 2'b00, 1'b0, 1'b1, ad);
      do_instr(32'h0000_FFFE, 2'b01, 1'b0, 1'b1, ad);
      check("t2_not_taken", pc, 30'h0000_0C06);

      // jump and reserved op
      do_reset();
      run = 1'b1;
      do_instr(32'h0000_0100, 2'b10, 1'b0, 1'b1, ad);
      check("t3_jump", pc, 30'h0000_0100);
      do_instr(32'h0000_0100, 2'b11, 1'b0, 1'b1, ad);
      check("t3_reserved", pc, 30'h0000_0101);

      // watchdog: one instruction, then withhold ack
      do_reset();
      run = 1'b1;
      do_instr(32'h0000_1234, 2'b00, 1'b0, 1'b1, ad);
      n = 0;
      while (imem_req === 1'b1 && n < 400) begin n++; step(); end
      check("t4_fetch_cycles", n, 32'd256);
      check("t4_fault", fault, 1'b1);
      check("t4_pc_frozen", pc, 30'h0000_0C01);
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; ex_done = 1'b1;
      step();
      imem_ack = 1'b0; ex_done = 1'b0;
      check("t4_late_ack_ir", ir, 32'h0000_1234);
      check("t4_retired_frozen", retired, 32'd1);
      do_reset();
      check("t4_fault_cleared", fault, 1'b0);
      check("t4_pc_reset", pc, RST_PC);

      // run dropped mid-fetch, ack four cycles later
      run = 1'b1;
      step();
      run = 1'b0;
      repeat (4) step();
      imem_ack = 1'b1; imem_rdata = 32'h0000_0042;
      step();
      imem_ack = 1'b0;
      check("t5_ir_valid", ir_valid, 1'b1);
      check("t5_ir", ir, 32'h0000_0042);
      step();
      check("t5_ir_valid_pulse", ir_valid, 1'b0);
      ex_done = 1'b1;
      step();
      ex_done = 1'b0;
      check("t5_pc", pc, 30'h0000_0C01);
      n = 0;
      repeat (5) begin if (imem_req === 1'b1) n++; step(); end
      check("t5_no_req", n, 32'd0);

      // reset in EXEC with ex_done, then wrap below zero and past the top
      do_reset();
      run = 1'b1;
      while (imem_req !== 1'b1 && n < 20) begin n++; step(); end
      imem_ack = 1'b1; imem_rdata = 32'h0000_0100;
      step();
      imem_ack = 1'b0;
      rst = 1'b1; ex_done = 1'b1; run = 1'b0;
      step();
      rst = 1'b0; ex_done = 1'b0;
      check("t6_rst_pc", pc, RST_PC);
      check("t6_rst_retired", retired, 32'd0);
      step();
      check("t6_idle_req", imem_req, 1'b0);
      run = 1'b1;
      do_instr(32'h0000_0100, 2'b10, 1'b0, 1'b1, ad);
      do_instr(32'h0000_FE00, 2'b01, 1'b1, 1'b1, ad);
      check("t6_wrap_below", pc, 30'h3FFF_FF00);
      do_instr(32'h03FF_FFFF, 2'b10, 1'b0, 1'b1, ad);
      check("t6_jump_top", pc, 30'h3FFF_FFFF);
      do_instr(32'h0, 2'b00, 1'b0, 1'b0, ad);
      check("t6_wrap_top", pc, 30'h0000_0000);
      check("t6_retired", retired, 32'd4);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
